// File: rtl/o_accum.sv
// o_accum -- row accumulator for a streaming attention output stage.
//
// Each accepted beat replaces the accumulator with the saturated
// element-wise sum of two upstream vectors. Upstream has already folded the
// previous accumulator (rescaled) into exp_o_in. After N_KEYS beats the
// finished row is presented on o_out/vld_out and held until downstream takes
// it. Then the accumulator and beat count clear for the next row.
//
// Ports
//   clk             : clock, rising edge
//   rst             : asynchronous active-high reset
//   vld_in          : upstream beat valid
//   rdy_out         : ready to accept a beat (low while draining or flushing)
//   exp_o_in        : rescaled previous accumulator, VEC_LEN x ELEM_W packed
//   exp_v_in        : scaled value vector, packed the same way
//   flush           : synchronous abort of the row being accumulated
//   o_star_prev_out : current accumulator, fed back upstream
//   key_idx         : beats accepted in the current row
//   vld_out         : finished row valid
//   rdy_in          : downstream ready
//   o_out           : finished row vector
module o_accum #(
  parameter int VEC_LEN = 16,
  parameter int ELEM_W  = 16,
  parameter int N_KEYS  = 64,
  localparam int KEY_W  = $clog2(N_KEYS + 1),
  localparam int VW     = VEC_LEN * ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  output logic              rdy_out,
  input  logic [VW-1:0]     exp_o_in,
  input  logic [VW-1:0]     exp_v_in,
  input  logic              flush,
  output logic [VW-1:0]     o_star_prev_out,
  output logic [KEY_W-1:0]  key_idx,
  output logic              vld_out,
  input  logic              rdy_in,
  output logic [VW-1:0]     o_out
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [KEY_W-1:0] KEY_ZERO = KEY_W'(0);
  localparam logic [KEY_W-1:0] KEY_ONE  = KEY_W'(1);
  localparam logic [KEY_W-1:0] KEY_LAST = KEY_W'(N_KEYS - 1);

  // Signed add at one extra bit, clamped to the element range.
  function automatic logic [ELEM_W-1:0] sat_add(input logic [ELEM_W-1:0] a,
                                                input logic [ELEM_W-1:0] b);
    logic [ELEM_W:0] s;
    s = {a[ELEM_W-1], a} + {b[ELEM_W-1], b};
    // The two top bits differ only when the true sum left the element range.
    if (s[ELEM_W] != s[ELEM_W-1]) begin
      if (s[ELEM_W]) begin
        sat_add = {1'b1, {(ELEM_W-1){1'b0}}};
      end else begin
        sat_add = {1'b0, {(ELEM_W-1){1'b1}}};
      end
    end else begin
      sat_add = s[ELEM_W-1:0];
    end
  endfunction

  state_t             state_r, state_s;
  logic [VW-1:0]      acc_r, acc_s;
  logic [KEY_W-1:0]   key_r, key_s;
  logic [VW-1:0]      out_r, out_s;
  logic [VW-1:0]      sum_s;
  logic               rdy_s;

  // Saturated element-wise sum of the two incoming vectors.
  always_comb begin
    sum_s = {VW{1'b0}};
    for (int i = 0; i < VEC_LEN; i++) begin
      sum_s[i*ELEM_W +: ELEM_W] = sat_add(exp_o_in[i*ELEM_W +: ELEM_W],
                                          exp_v_in[i*ELEM_W +: ELEM_W]);
    end
  end

  // Next-state, accumulator, beat count and ready decisions.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    key_s   = key_r;
    out_s   = out_r;
    rdy_s   = 1'b0;
    case (state_r)
      ACCUM: begin
        rdy_s = !flush;
        if (flush) begin
          // Flush wins over a simultaneous beat.
          acc_s = {VW{1'b0}};
          key_s = KEY_ZERO;
        end else if (vld_in) begin
          acc_s = sum_s;
          key_s = key_r + KEY_ONE;
          if (key_r == KEY_LAST) begin
            state_s = DRAIN;
            out_s   = sum_s;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      DRAIN: begin
        // flush is ignored here so a completed row is always delivered.
        if (rdy_in) begin
          state_s = ACCUM;
          acc_s   = {VW{1'b0}};
          key_s   = KEY_ZERO;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = ACCUM;
        acc_s   = {VW{1'b0}};
        key_s   = KEY_ZERO;
      end
    endcase
  end

  // State, accumulator, beat count and output row registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ACCUM;
      acc_r   <= {VW{1'b0}};
      key_r   <= KEY_ZERO;
      out_r   <= {VW{1'b0}};
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      key_r   <= key_s;
      out_r   <= out_s;
    end
  end

  assign rdy_out         = rdy_s;
  assign vld_out         = (state_r == DRAIN);
  assign o_star_prev_out = acc_r;
  assign key_idx         = key_r;
  assign o_out           = out_r;

endmodule

// File: tb/tb_o_accum.sv
// Self-checking bench for o_accum at VEC_LEN=4, ELEM_W=8, N_KEYS=3.
// A behavioural model of the row (integer element arrays, beat count and a
// "row pending" flag) predicts every output; directed steps cover the basic
// row, saturation, backpressure, flush, async reset and back-to-back rows,
// followed by a randomized stretch.
module tb_o_accum;

  localparam int VEC_LEN = 4;
  localparam int ELEM_W  = 8;
  localparam int N_KEYS  = 3;
  localparam int VW      = VEC_LEN * ELEM_W;
  localparam int KEY_W   = $clog2(N_KEYS + 1);

  typedef int vec4_t [VEC_LEN];

  logic              clk = 1'b0;
  logic              rst;
  logic              vld_in;
  logic              rdy_out;
  logic [VW-1:0]     exp_o_in;
  logic [VW-1:0]     exp_v_in;
  logic              flush;
  logic [VW-1:0]     o_star_prev_out;
  logic [KEY_W-1:0]  key_idx;
  logic              vld_out;
  logic              rdy_in;
  logic [VW-1:0]     o_out;

  o_accum #(.VEC_LEN(VEC_LEN), .ELEM_W(ELEM_W), .N_KEYS(N_KEYS)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
    .exp_o_in(exp_o_in), .exp_v_in(exp_v_in), .flush(flush),
    .o_star_prev_out(o_star_prev_out), .key_idx(key_idx), .vld_out(vld_out),
    .rdy_in(rdy_in), .o_out(o_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  vec4_t m_acc;
  vec4_t m_out;
  int    m_key;
  bit    m_pending;

  vec4_t eo;
  vec4_t ev;
  bit    last_rdy;
  int    idle_cnt;

  function automatic int clamp8(int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic logic [VW-1:0] pack4(vec4_t a);
    logic [VW-1:0] r;
    r = {VW{1'b0}};
    for (int i = 0; i < VEC_LEN; i++) r[i*ELEM_W +: ELEM_W] = 8'(a[i]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < VEC_LEN; i++) begin
      m_acc[i] = 0;
      m_out[i] = 0;
    end
    m_key = 0;
    m_pending = 1'b0;
  endtask

  task automatic set_all(input int o, input int v);
    for (int i = 0; i < VEC_LEN; i++) begin
      eo[i] = o;
      ev[i] = v;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < VEC_LEN; i++) begin
      eo[i] = int'($urandom_range(255)) - 128;
      ev[i] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":acc"}, 32'(o_star_prev_out), 32'(pack4(m_acc)));
    chk({tag, ":key"}, 32'(key_idx), 32'(m_key));
    chk({tag, ":vld"}, 32'(vld_out), 32'(m_pending));
    if (m_pending) chk({tag, ":oout"}, 32'(o_out), 32'(pack4(m_out)));
  endtask

  // One clock cycle: drive inputs, check ready, advance the model, check outputs.
  task automatic tick(input bit v, input bit f, input bit r, input string tag);
    vld_in   = v;
    flush    = f;
    rdy_in   = r;
    exp_o_in = pack4(eo);
    exp_v_in = pack4(ev);
    #2;
    last_rdy = rdy_out;
    chk({tag, ":rdy"}, 32'(rdy_out), 32'(!m_pending && !f));
    if (!m_pending) begin
      if (f) begin
        for (int i = 0; i < VEC_LEN; i++) m_acc[i] = 0;
        m_key = 0;
      end else if (v) begin
        for (int i = 0; i < VEC_LEN; i++) m_acc[i] = clamp8(eo[i] + ev[i]);
        m_key++;
        if (m_key == N_KEYS) begin
          m_pending = 1'b1;
          m_out = m_acc;
        end
      end
    end else if (r) begin
      for (int i = 0; i < VEC_LEN; i++) m_acc[i] = 0;
      m_key = 0;
      m_pending = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic rand_row(input bit r_last, input string tag);
    for (int k = 0; k < N_KEYS; k++) begin
      set_rand();
      tick(1'b1, 1'b0, r_last, tag);
    end
  endtask

  initial begin
    rst = 1'b1; vld_in = 1'b0; flush = 1'b0; rdy_in = 1'b0;
    exp_o_in = {VW{1'b0}}; exp_v_in = {VW{1'b0}};
    set_all(0, 0);
    model_reset();
    #1;
    chk("reset:rdy", 32'(rdy_out), 32'd1);
    chk("reset:vld", 32'(vld_out), 32'd0);
    chk("reset:key", 32'(key_idx), 32'd0);
    chk("reset:acc", 32'(o_star_prev_out), 32'd0);
    chk("reset:oout", 32'(o_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic row
    set_all(0, 1); tick(1'b1, 1'b0, 1'b1, "basic1");
    chk("basic1:const", 32'(o_star_prev_out), 32'h01010101);
    set_all(1, 2); tick(1'b1, 1'b0, 1'b1, "basic2");
    chk("basic2:const", 32'(o_star_prev_out), 32'h03030303);
    set_all(3, 4); tick(1'b1, 1'b0, 1'b1, "basic3");
    chk("basic3:const", 32'(o_star_prev_out), 32'h07070707);
    chk("basic3:vldconst", 32'(vld_out), 32'd1);
    chk("basic3:ooutconst", 32'(o_out), 32'h07070707);
    set_all(0, 0); tick(1'b0, 1'b0, 1'b1, "basic_hs");
    chk("basic_hs:acc0", 32'(o_star_prev_out), 32'd0);

    // Saturation, then backpressure on the finished row
    set_all(0, 0);
    eo[0] = 100; ev[0] = 100; eo[1] = -100; ev[1] = -100;
    tick(1'b1, 1'b0, 1'b0, "sat1");
    chk("sat:e0", 32'(o_star_prev_out[7:0]), 32'h7f);
    chk("sat:e1", 32'(o_star_prev_out[15:8]), 32'h80);
    tick(1'b1, 1'b0, 1'b0, "sat2");
    tick(1'b1, 1'b0, 1'b0, "sat3");
    for (int c = 0; c < 5; c++) begin
      set_rand();
      tick(c[0], c[1], 1'b0, "bp");
      chk("bp:key3", 32'(key_idx), 32'd3);
    end
    tick(1'b0, 1'b0, 1'b1, "bp_hs");

    // Flush together with a beat after two beats
    rand_row(1'b1, "pre");
    tick(1'b0, 1'b0, 1'b1, "pre_hs");
    set_rand(); tick(1'b1, 1'b0, 1'b1, "fl1");
    set_rand(); tick(1'b1, 1'b0, 1'b1, "fl2");
    set_rand(); tick(1'b1, 1'b1, 1'b1, "fl_flush");
    chk("fl:key0", 32'(key_idx), 32'd0);
    chk("fl:acc0", 32'(o_star_prev_out), 32'd0);
    rand_row(1'b1, "fl_row");
    tick(1'b0, 1'b0, 1'b1, "fl_hs");

    // Async reset while a finished row is pending
    rand_row(1'b0, "ar_row");
    tick(1'b0, 1'b0, 1'b0, "ar_hold");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("ar:vld", 32'(vld_out), 32'd0);
    chk("ar:rdy", 32'(rdy_out), 32'd1);
    chk("ar:key", 32'(key_idx), 32'd0);
    chk("ar:acc", 32'(o_star_prev_out), 32'd0);
    chk("ar:oout", 32'(o_out), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    set_rand(); tick(1'b1, 1'b0, 1'b1, "ar_b1");
    set_rand(); tick(1'b1, 1'b0, 1'b1, "ar_b2");
    set_rand(); tick(1'b1, 1'b0, 1'b1, "ar_b3");
    tick(1'b0, 1'b0, 1'b1, "ar_hs");

    // Back-to-back rows with vld_in held high
    idle_cnt = 0;
    for (int c = 0; c < 2 * N_KEYS + 1; c++) begin
      set_rand();
      tick(1'b1, 1'b0, 1'b1, "b2b");
      if (!last_rdy) idle_cnt++;
    end
    chk("b2b:idle", 32'(idle_cnt), 32'd1);
    tick(1'b0, 1'b0, 1'b1, "b2b_hs");

    // Randomized traffic
    for (int c = 0; c < 80; c++) begin
      set_rand();
      tick($urandom_range(3) != 0, $urandom_range(7) == 0,
           $urandom_range(1) == 1, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/o_accum.md
O_ACCUM -- requirements
Module: o_accum

Interface
REQ-001 Parameter VEC_LEN, default 16, number of elements per output vector.
REQ-002 Parameter ELEM_W, default 16, width of each signed two's-complement element.
REQ-003 Parameter N_KEYS, default 64, number of accepted beats per query row; legal range is at least 1.
REQ-004 Port clk, input, 1, the single clock; all state is on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port vld_in, input, 1, upstream beat valid.
REQ-007 Port rdy_out, output, 1, this block ready to accept a beat.
REQ-008 Port exp_o_in, input, VEC_LEN*ELEM_W, rescaled previous accumulator; element i is at bits [i*ELEM_W +: ELEM_W].
REQ-009 Port exp_v_in, input, VEC_LEN*ELEM_W, scaled value vector, packed the same way.
REQ-010 Port flush, input, 1, synchronous abort of the current row.
REQ-011 Port o_star_prev_out, output, VEC_LEN*ELEM_W, current accumulator, fed back upstream.
REQ-012 Port key_idx, output, $clog2(N_KEYS+1), number of beats accepted in the current row.
REQ-013 Port vld_out, output, 1, finished row vector valid.
REQ-014 Port rdy_in, input, 1, downstream ready.
REQ-015 Port o_out, output, VEC_LEN*ELEM_W, finished row vector.

Function
REQ-016 The FSM SHALL have two states: ACCUM and DRAIN.
REQ-017 In ACCUM, rdy_out SHALL equal !flush; in DRAIN, rdy_out SHALL be 0.
REQ-018 A beat is accepted when vld_in && rdy_out are both high; on acceptance, each element of the accumulator SHALL be set, on the next edge, to sat(exp_o_in[i] + exp_v_in[i]).
REQ-019 sat SHALL compute the sum at ELEM_W+1 bits signed and clamp it to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1].
REQ-020 The old accumulator value SHALL NOT be added to the sum; upstream has already folded it into exp_o_in.
REQ-021 o_star_prev_out SHALL be driven directly from the accumulator register.
REQ-022 key_idx SHALL increment by 1 on each accepted beat.
REQ-023 The beat that brings key_idx to N_KEYS SHALL move the FSM to DRAIN on the same edge, and o_out SHALL equal the new accumulator value.
REQ-024 Latency: vld_out SHALL be 1 on the first cycle after the final beat is accepted.
REQ-025 In DRAIN, vld_out SHALL be 1, and o_out and vld_out SHALL stay stable until vld_out && rdy_in.
REQ-026 On the DRAIN handshake, the accumulator and key_idx SHALL clear to 0 and the FSM SHALL return to ACCUM on the next edge.
REQ-027 No beat SHALL be accepted in the DRAIN-handshake cycle.
REQ-028 When flush is high in ACCUM, the accumulator and key_idx SHALL clear to 0 on the next edge and no beat SHALL be accepted; flush takes priority over vld_in.
REQ-029 flush in DRAIN SHALL be ignored; a completed row is always delivered.
REQ-030 When N_KEYS=1, every accepted beat SHALL move the FSM directly to DRAIN.
REQ-031 When vld_in is low, the accumulator, key_idx, and state SHALL hold their values.

Reset
REQ-032 While rst is high, the FSM SHALL be in ACCUM with the accumulator=0, key_idx=0, o_out=0, vld_out=0, and rdy_out=1; all of these take effect asynchronously.
REQ-033 Reset asserted mid-row or in DRAIN SHALL discard the partial or pending row; no vld_out SHALL follow reset deassertion until N_KEYS new beats have been accepted.

Verification (VEC_LEN=4, ELEM_W=8, N_KEYS=3)
REQ-034 Basic row: send beats of (exp_o, exp_v) = (0,1), (1,2), (3,4) on all elements with rdy_in=1.
  - Required: o_star_prev_out reads 1, 3, 7 after each beat.
  - Required: vld_out=1 with o_out=7 on all elements, one cycle after the third beat.
  - Required: the accumulator reads 0 after the output handshake.
REQ-035 Saturation: send element 0 = (100,100) and element 1 = (-100,-100).
  - Required: the results are 127 and -128 respectively.
REQ-036 Backpressure: complete a row, then hold rdy_in=0 for 5 cycles.
  - Required: o_out is stable, vld_out=1, and rdy_out=0 throughout.
  - Required: vld_in pulses in that window are not accepted (key_idx stays 3).
REQ-037 Flush: flush together with vld_in after 2 beats.
  - Required: the beat is not accepted, and key_idx and the accumulator read 0.
  - Required: the next row needs 3 fresh beats before vld_out rises.
REQ-038 Async reset: assert rst between clock edges while in DRAIN.
  - Required: vld_out drops immediately and rdy_out=1.
  - Required: the outputs match REQ-032 before the next edge.
REQ-039 Back-to-back: two rows with vld_in held high and rdy_in=1.
  - Required: exactly one idle input cycle occurs between rows, in the DRAIN cycle.
  - Required: both o_out values are correct.
